// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector multiply scheduler.
package matvec_pkg;

    // One 4-element column vector of IEEE-754 single words.
    typedef logic [3:0][31:0] vec4_t;

    // 4x4 matrix, row-major: element [r] is row r.
    typedef vec4_t [3:0] mat4_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/matvec_sched_if.sv
// Request, response and multiply-unit channels of the scheduler.
interface matvec_sched_if
    import matvec_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0] req_valid_in;
    logic [NUM_REQ-1:0] req_ready_out;
    mat4_t [NUM_REQ-1:0] req_mat_in;
    vec4_t [NUM_REQ-1:0] req_vec_in;
    logic [NUM_REQ-1:0] rsp_valid_out;
    logic [NUM_REQ-1:0] rsp_ready_in;
    vec4_t rsp_vec_out;
    logic rsp_err_out;
    logic mm_valid_out;
    mat4_t mm_mat_out;
    vec4_t mm_vec_out;
    logic mm_valid_in;
    vec4_t mm_vec_in;
    logic busy_out;
    logic stray_out;
    logic [CNT_W-1:0] done_cnt_out;

    // Scheduler side.
    modport slave (
        input  req_valid_in, req_mat_in, req_vec_in, rsp_ready_in,
               mm_valid_in, mm_vec_in,
        output req_ready_out, rsp_valid_out, rsp_vec_out, rsp_err_out,
               mm_valid_out, mm_mat_out, mm_vec_out, busy_out, stray_out,
               done_cnt_out
    );

    // Requesters plus multiply unit side.
    modport master (
        output req_valid_in, req_mat_in, req_vec_in, rsp_ready_in,
               mm_valid_in, mm_vec_in,
        input  req_ready_out, rsp_valid_out, rsp_vec_out, rsp_err_out,
               mm_valid_out, mm_mat_out, mm_vec_out, busy_out, stray_out,
               done_cnt_out
    );
endinterface

// File: rtl/matvec_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_in, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_in,
    input  logic [IW-1:0] ptr_in,
    output logic [N-1:0]  gnt_out,
    output logic [IW-1:0] idx_out
);
    logic          w_found;
    logic [IW-1:0] w_k;

    // Scan N positions starting at the pointer; first hit wins.
    always_comb begin
        gnt_out = '0;
        idx_out = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = IW'((int'(ptr_in) + i) % N);
            if (!w_found && req_in[w_k]) begin
                w_found      = 1'b1;
                gnt_out[w_k] = 1'b1;
                idx_out      = w_k;
            end
        end
    end
endmodule

// File: rtl/matvec_sched.sv
// Round-robin scheduler for the shared 4x4 * 4-vector multiply unit.
// One job in flight; result watched with a timeout, returned to its owner.
module matvec_sched
    import matvec_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    matvec_sched_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_t       r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_owner;
    mat4_t              r_mat;
    vec4_t              r_vec;
    vec4_t              r_res;
    logic               r_err;
    logic [TW-1:0]      r_tcnt;
    logic               r_mm_valid;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_stray;
    logic [CNT_W-1:0]   r_done_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_rsp_hs;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_in  (bus.req_valid_in),
        .ptr_in  (r_rr_ptr),
        .gnt_out (w_gnt),
        .idx_out (w_gnt_idx)
    );

    // Accept only in IDLE; held low during reset so outputs read zero.
    assign bus.req_ready_out = (r_state == S_IDLE && rst_n_in) ? w_gnt : '0;
    assign w_rsp_hs          = (r_state == S_RESP) && bus.rsp_ready_in[r_owner];

    assign bus.rsp_valid_out = r_rsp_valid;
    assign bus.rsp_vec_out   = r_res;
    assign bus.rsp_err_out   = r_err;
    assign bus.mm_valid_out  = r_mm_valid;
    assign bus.mm_mat_out    = r_mat;
    assign bus.mm_vec_out    = r_vec;
    assign bus.busy_out      = (r_state != S_IDLE);
    assign bus.stray_out     = r_stray;
    assign bus.done_cnt_out  = r_done_cnt;

    // Job sequencer: accept -> issue strobe -> wait/timeout -> response.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_mat       <= '0;
            r_vec       <= '0;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_tcnt      <= '0;
            r_mm_valid  <= 1'b0;
            r_rsp_valid <= '0;
            r_stray     <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            r_mm_valid <= 1'b0;
            // A result outside WAIT has no job to belong to: drop it, flag it.
            if (bus.mm_valid_in && r_state != S_WAIT)
                r_stray <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (|w_gnt) begin
                        r_mat      <= bus.req_mat_in[w_gnt_idx];
                        r_vec      <= bus.req_vec_in[w_gnt_idx];
                        r_owner    <= w_gnt_idx;
                        r_mm_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // A result on the timeout cycle still counts as good.
                    if (bus.mm_valid_in) begin
                        r_res       <= bus.mm_vec_in;
                        r_err       <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= S_RESP;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_res       <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                        r_done_cnt  <= r_done_cnt + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_sched.sv
// Directed bench: table of jobs plus hand-written timeout/stray/reset sequences.
module tb_matvec_sched;
    import matvec_pkg::*;

    localparam int NR = 2;
    localparam int TO = 64;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matvec_sched_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    matvec_sched #(.NUM_REQ(NR), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [NR-1:0] mask;   // req_valid pattern
        int            owner;  // expected grant
        int            k;      // WAIT cycle index of result, -1 = never
        int            hold;   // cycles owner withholds rsp_ready
        logic          err;    // expected rsp_err
        vec4_t         res;    // model result / expected response
    } tv_t;

    tv_t   tv[9];
    mat4_t mat[NR];
    vec4_t vin[NR];
    vec4_t r1, r4;
    int    n_chk = 0;
    int    n_pass = 0;
    int    exp_done = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, {bus.req_ready_out, bus.rsp_valid_out, bus.rsp_err_out,
                            bus.mm_valid_out, bus.busy_out, bus.stray_out,
                            bus.done_cnt_out, bus.mm_vec_out, bus.rsp_vec_out}, '0);
        chk({nm, "_mat"}, bus.mm_mat_out, '0);
    endtask

    task automatic run_job(input tv_t t);
        logic [NR-1:0] oh;
        int w;
        oh = NR'(1) << t.owner;
        bus.req_valid_in = t.mask;
        #1;
        w = 0;
        while (bus.req_ready_out == '0 && w < 50) begin
            tick();
            w++;
        end
        chk("accept_latency", w, 0);
        chk("req_ready", bus.req_ready_out, oh);
        tick();
        chk("mm_valid_issue", bus.mm_valid_out, 1'b1);
        chk("mm_mat", bus.mm_mat_out, mat[t.owner]);
        chk("mm_vec", bus.mm_vec_out, vin[t.owner]);
        chk("ready_busy", bus.req_ready_out, '0);
        tick();
        chk("mm_valid_single", bus.mm_valid_out, 1'b0);
        if (t.k >= 0) begin
            repeat (t.k) tick();
            bus.mm_valid_in = 1'b1;
            bus.mm_vec_in   = t.res;
            tick();
            bus.mm_valid_in = 1'b0;
            bus.mm_vec_in   = '0;
        end else begin
            w = 0;
            while (bus.rsp_valid_out == '0 && w < 200) begin
                tick();
                w++;
            end
            chk("timeout_cycles", w, TO);
        end
        chk("rsp_valid", bus.rsp_valid_out, oh);
        chk("rsp_vec", bus.rsp_vec_out, t.res);
        chk("rsp_err", bus.rsp_err_out, t.err);
        // Non-owner ready must be ignored while the owner stalls.
        bus.rsp_ready_in = ~oh;
        repeat (t.hold) begin
            tick();
            chk("rsp_hold", {bus.rsp_valid_out, bus.rsp_err_out, bus.mm_valid_out,
                             bus.req_ready_out, bus.rsp_vec_out},
                            {oh, t.err, 1'b0, NR'(0), t.res});
        end
        bus.rsp_ready_in = oh;
        tick();
        bus.rsp_ready_in = '0;
        bus.req_valid_in = '0;
        exp_done++;
        chk("rsp_drop", bus.rsp_valid_out, '0);
        chk("done_cnt", bus.done_cnt_out, exp_done);
        chk("busy_idle", bus.busy_out, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat[0][r][c] = (r == c) ? FP_ONE : FP_ZERO;
                mat[1][r][c] = 32'h4000_0000 + 32'(r * 4 + c);
            end
        vin[0][0] = 32'h3F80_0000; vin[0][1] = 32'h4000_0000;
        vin[0][2] = 32'h4040_0000; vin[0][3] = 32'h3F80_0000;
        vin[1][0] = 32'h4100_0000; vin[1][1] = 32'h4110_0000;
        vin[1][2] = 32'h4120_0000; vin[1][3] = 32'h4130_0000;
        r1[0] = 32'hC000_0000; r1[1] = 32'h3F00_0000;
        r1[2] = 32'h0000_0000; r1[3] = 32'h4200_0000;
        r4[0] = 32'h4080_0000; r4[1] = FP_ZERO;
        r4[2] = FP_ZERO;       r4[3] = FP_ONE;

        tv[0] = '{2'b01, 0,  8,  0, 1'b0, vin[0]};
        tv[1] = '{2'b11, 1,  3,  0, 1'b0, r1};
        tv[2] = '{2'b11, 0,  0,  0, 1'b0, vin[0]};
        tv[3] = '{2'b11, 1,  5,  0, 1'b0, r1};
        tv[4] = '{2'b11, 0,  2,  0, 1'b0, vin[0]};
        tv[5] = '{2'b11, 1,  4, 20, 1'b0, r1};
        tv[6] = '{2'b11, 0,  1,  0, 1'b0, vin[0]};
        tv[7] = '{2'b01, 0, -1,  0, 1'b1, vec4_t'(0)};
        tv[8] = '{2'b01, 0, 63,  0, 1'b0, r4};

        bus.req_valid_in = 2'b11;
        bus.rsp_ready_in = '0;
        bus.mm_valid_in  = 1'b0;
        bus.mm_vec_in    = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_mat_in[i] = mat[i];
            bus.req_vec_in[i] = vin[i];
        end
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid_in = '0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_job(tv[i]);
            if (tv[i].err) begin
                // Late result after a timeout: dropped, flagged, no response.
                chk("stray_pre", bus.stray_out, 1'b0);
                repeat (4) tick();
                bus.mm_valid_in = 1'b1;
                bus.mm_vec_in   = r1;
                tick();
                bus.mm_valid_in = 1'b0;
                bus.mm_vec_in   = '0;
                chk("stray_set", bus.stray_out, 1'b1);
                repeat (3) tick();
                chk("stray_no_rsp", {bus.rsp_valid_out, bus.busy_out}, '0);
            end
        end

        // Reset in the middle of WAIT: job lost, everything back to zero.
        bus.req_valid_in = 2'b10;
        #1;
        chk("pre_rst_grant", bus.req_ready_out, 2'b10);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", bus.busy_out, 1'b1);
        #2;
        bus.req_valid_in = 2'b11;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ptr", bus.req_ready_out, 2'b01);
        exp_done = 0;
        run_job(tv[2]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matvec_sched.md
Name: matvec_sched

Overview:
Arbiter and sequencer for the shared 4x4-matrix by 4-vector floating-point multiply unit in the 3D pipeline. NUM_REQ requesters (e.g. model/view transform, projection, lighting-normal transform) each present a matrix plus vector. The block grants the unit round-robin and holds exactly one job in flight. It watches the result with a timeout and returns the result vector to the owning requester over a valid/ready response channel.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 64, max cycles from issue to datapath result before the job is aborted (>=2)
CNT_W, 16, width of per-block completed-job counter

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
req_valid_in  input  NUM_REQ  per-requester job valid
req_ready_out  output  NUM_REQ  per-requester job accept (one-hot or zero)
req_mat_in  input  NUM_REQ x 4 x 4 x 32  per-requester matrix, row-major, IEEE-754 single
req_vec_in  input  NUM_REQ x 4 x 32  per-requester column vector
rsp_valid_out  output  NUM_REQ  result valid to owning requester (one-hot or zero)
rsp_ready_in  input  NUM_REQ  requester accepts result
rsp_vec_out  output  4 x 32  result vector (shared bus, qualified by rsp_valid_out)
rsp_err_out  output  1  result is a timeout abort (vector forced to zero)
mm_valid_out  output  1  one-cycle issue strobe to multiply unit
mm_mat_out  output  4 x 4 x 32  latched matrix, stable from issue until result/abort
mm_vec_out  output  4 x 32  latched vector, same stability rule
mm_valid_in  input  1  multiply unit result strobe
mm_vec_in  input  4 x 32  multiply unit result
busy_out  output  1  state != IDLE
stray_out  output  1  sticky: mm_valid_in seen outside WAIT
done_cnt_out  output  CNT_W  completed responses (incl. errors), wraps

Behaviour:
- Reset (async assert, sync deassert externally): state IDLE. rr_ptr=0. All outputs 0. Latched operands 0. Timeout counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first requester with req_valid_in high, searching from rr_ptr upward modulo NUM_REQ. req_ready_out[grant]=1 combinationally in that cycle. No combinational path from ready to valid. On the handshake, latch mat/vec and owner, then go to ISSUE. No valid inputs: stay.
- ISSUE: mm_valid_out=1 for exactly this cycle. Clear timeout counter. Go to WAIT.
- WAIT: counter increments each cycle.
  - mm_valid_in=1: capture mm_vec_in into result register, rsp_err=0, go to RESP.
  - Otherwise, counter==TIMEOUT-1: result=0, rsp_err=1, go to RESP.
  - mm_valid_in on the same cycle as the timeout: the result wins, err=0.
- RESP: rsp_valid_out[owner]=1, rsp_vec_out/rsp_err_out held stable until rsp_ready_in[owner]=1. On handshake: rr_ptr=(owner+1) mod NUM_REQ, done_cnt+1 (wraps at 2^CNT_W), go to IDLE. rsp_ready_in of non-owners is ignored.
- Latency: accept at cycle T, issue at T+1. Response valid the cycle after mm_valid_in. With zero backpressure, the next accept is possible the cycle after the response handshake.
- mm_valid_in in IDLE/ISSUE/RESP: data dropped, stray_out set (cleared only by reset). This includes a late result arriving after a timeout or after reset.
- Reset mid-job: job lost silently. Requester must re-request.
- req_valid deassertion before grant is permitted. A requester holding valid is served within NUM_REQ jobs (fairness bound).
- No arithmetic in this block. The 32-bit words are passed through unmodified.

Decomposition:
- Package matvec_pkg:
  - vec4_t (4x32 packed)
  - mat4_t (4 x vec4_t)
  - sched_state_t enum
  - FP_ONE=32'h3F800000
  - FP_ZERO=32'h0
- Sub-module rr_arbiter: parameter N. Inputs req[N] and ptr. Outputs one-hot grant and encoded index. Purely combinational, reused by later raster/memory schedulers.

Test Plan:
- Single requester 0, identity matrix, vec {3F800000,40000000,40400000,3F800000}; model unit returns same vec after 10 cycles -> mm_valid_out one pulse at T+1; rsp_valid_out=01 with identical vec, err=0; done_cnt=1.
- Both requesters valid continuously for 4 jobs -> grants 0,1,0,1. req_ready_out never two-hot. mm operands match the granted requester each time.
- Requester 1 holds rsp_ready_in low 20 cycles while requester 0 is waiting -> rsp outputs stable throughout. No new issue until handshake. Requester 0 is then granted next.
- Model never responds -> after TIMEOUT=64 cycles in WAIT: rsp_err_out=1, rsp_vec_out=0. A late mm_valid_in 5 cycles later sets stray_out=1 and produces no response.
- mm_valid_in on exactly the timeout cycle with vec {40800000,0,0,3F800000} -> err=0, that vec returned.
- rst_n_in pulsed low during WAIT -> all outputs 0 immediately (async), state IDLE, rr_ptr=0. A subsequent request completes normally.
